// File: rtl/imem_refill_responder_if.sv
// Refill link between the instruction cache (master) and its backing store (slave).
// Carries the request channel, the critical-word-first response burst, the busy flag and the preload write port.
// Parameters must match the ones given to imem_refill_responder on the same link.
interface imem_refill_responder_if #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  // request channel: one outstanding line refill, word-addressed
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_abort;

  // response burst: WORDS_PER_LINE beats, critical word first, wrapping inside the line
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [IDX_W-1:0]  rsp_idx;
  logic              rsp_last;

  logic              busy;

  // preload write port for program images
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  modport master (
    output req_valid, req_addr, req_abort, rsp_ready, ld_we, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_addr, req_abort, rsp_ready, ld_we, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, busy
  );
endinterface

// File: rtl/imem_refill_responder.sv
// Backing-store responder answering Icache line refills critical-word-first, with abort and a preload write port.
// Latency: first beat LATENCY cycles after the accept edge, then one beat per rsp handshake; one idle cycle between lines.
// Backpressure: rsp_ready low holds the current beat registered; req_ready is high only while idle.
// Ports: clk, rst (async active-low), bus (slave side of imem_refill_responder_if: req_*, rsp_*, busy, ld_*).
module imem_refill_responder #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LATENCY        = 3,
  parameter int MEM_DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  imem_refill_responder_if.slave  bus
);
  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int MEM_W  = $clog2(MEM_DEPTH);
  localparam int LINE_W = MEM_W - IDX_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int BEAT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;    // storage line index of the outstanding refill
  logic [IDX_W-1:0]  start_q, start_d;  // critical-word offset
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic [BEAT_W-1:0] beat_q, beat_d;    // 1-based number of the beat on the bus
  logic [31:0]       data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q, last_d;

  logic [31:0]       mem [MEM_DEPTH];

  // Addresses alias modulo MEM_DEPTH; the high bits are intentionally dropped.
  logic [LINE_W-1:0] req_line;
  logic [IDX_W-1:0]  req_off;
  logic [IDX_W-1:0]  idx_inc;
  logic              unused_addr_hi;

  assign req_line       = bus.req_addr[MEM_W-1:IDX_W];
  assign req_off        = bus.req_addr[IDX_W-1:0];
  assign idx_inc        = idx_q + 1'b1;  // wraps inside the line
  assign unused_addr_hi = ^{bus.req_addr[ADDR_W-1:MEM_W], bus.ld_addr[ADDR_W-1:MEM_W]};

  // Preload store. Beats loaded on the same edge read the old word because
  // the read happens combinationally before this edge commits the write.
  always_ff @(posedge clk) begin
    if (bus.ld_we) begin
      mem[bus.ld_addr[MEM_W-1:0]] <= bus.ld_data;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    start_d = start_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        // req_abort has no meaning here; a coincident request is accepted
        if (bus.req_valid) begin
          line_d  = req_line;
          start_d = req_off;
          if (LATENCY == 1) begin
            state_d = BURST;
            data_d  = mem[{req_line, req_off}];
            idx_d   = req_off;
            beat_d  = BEAT_W'(1);
            last_d  = 1'b0;
          end else begin
            state_d = WAIT;
            lat_d   = CNT_W'(LATENCY - 1);
          end
        end
      end

      WAIT: begin
        if (bus.req_abort) begin
          state_d = IDLE;
        end else if (lat_q == CNT_W'(1)) begin
          // loading on the count-of-one edge puts the first beat exactly
          // LATENCY cycles after the accept edge
          state_d = BURST;
          data_d  = mem[{line_q, start_q}];
          idx_d   = start_q;
          beat_d  = BEAT_W'(1);
          last_d  = 1'b0;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      BURST: begin
        // an abort coinciding with the last handshake lands in IDLE too
        if (bus.req_abort || (bus.rsp_ready && last_q)) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (bus.rsp_ready) begin
          idx_d  = idx_inc;
          data_d = mem[{line_q, idx_inc}];
          beat_d = beat_q + 1'b1;
          last_d = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      start_q <= '0;
      lat_q   <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      start_q <= start_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // every output is a register or a decode of the state register
  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == BURST);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_idx   = idx_q;
  assign bus.rsp_last  = last_q;
endmodule

// File: tb/tb_imem_refill_responder.sv
// Scoreboard bench for imem_refill_responder: DUT 0 at LATENCY=3, DUT 1 at LATENCY=1, shared reset and preload.
// Expected beats come from a word-array model of the store and are queued when a request is issued.
// A monitor compares every presented beat against the queue head and pops on handshake.
module tb_imem_refill_responder;
  localparam int W     = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        req_valid_v, req_abort_v, force_stall, rnd_bit, rsp_rdy_w;
  logic [1:0][31:0]  req_addr_v;
  logic              rnd_mode;
  logic              ld_we;
  logic [31:0]       ld_addr, ld_data;

  logic [1:0]        req_ready_v, rsp_valid_v, rsp_last_v, busy_v;
  logic [1:0][31:0]  rsp_data_v;
  logic [1:0][1:0]   rsp_idx_v;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_refill_responder_if #(.ADDR_W(32), .WORDS_PER_LINE(W)) bus ();

    assign rsp_rdy_w[g]  = !force_stall[g] && (!rnd_mode || rnd_bit[g]);
    assign bus.req_valid = req_valid_v[g];
    assign bus.req_addr  = req_addr_v[g];
    assign bus.req_abort = req_abort_v[g];
    assign bus.rsp_ready = rsp_rdy_w[g];
    assign bus.ld_we     = ld_we;
    assign bus.ld_addr   = ld_addr;
    assign bus.ld_data   = ld_data;
    assign req_ready_v[g] = bus.req_ready;
    assign rsp_valid_v[g] = bus.rsp_valid;
    assign rsp_data_v[g]  = bus.rsp_data;
    assign rsp_idx_v[g]   = bus.rsp_idx;
    assign rsp_last_v[g]  = bus.rsp_last;
    assign busy_v[g]      = bus.busy;

    imem_refill_responder #(
      .ADDR_W(32), .WORDS_PER_LINE(W), .LATENCY((g == 0) ? 3 : 1), .MEM_DEPTH(DEPTH)
    ) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus.slave)
    );
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line model: critical word first, wrapping inside the aligned line,
  // storage index taken modulo DEPTH.
  function automatic void push_line(input logic [31:0] a);
    logic [31:0] base;
    int          off;
    base = a & ~32'(W - 1);
    off  = int'(a % W);
    for (int i = 0; i < W; i++) begin
      beat_t       b;
      int          o;
      logic [31:0] ix;
      o      = (off + i) % W;
      ix     = (base + 32'(o)) % DEPTH;
      b.data = ref_mem[ix[7:0]];
      b.idx  = 2'(o);
      b.last = (i == W - 1);
      exp_q.push_back(b);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    rnd_bit = 2'($urandom);
  end

  // monitor: sampled late in the low phase, after the stimulus has set rsp_ready
  always begin
    @(negedge clk);
    #3;
    for (int g = 0; g < 2; g++) begin
      if (rsp_valid_v[g]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat dut%0d: got data %h, expected no beat", g, rsp_data_v[g]);
        end else begin
          check("beat_data", rsp_data_v[g], exp_q[0].data);
          check("beat_idx", 32'(rsp_idx_v[g]), 32'(exp_q[0].idx));
          check("beat_last", 32'(rsp_last_v[g]), 32'(exp_q[0].last));
          if (rsp_rdy_w[g]) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the idle cycle after the line.
  task automatic run_line(input int sel, input logic [31:0] a, input int exp_lat,
                          input int stall_at, input int stall_len, input bit ld_first,
                          input int rst_after, input bit chk_timing, input bit abort_at_acc,
                          output int ready_wait);
    int n, beats, vcyc, stalled;
    bit hs;
    ready_wait = 0;
    while (!req_ready_v[sel] && ready_wait < 50) begin
      @(negedge clk);
      ready_wait++;
    end
    if (!req_ready_v[sel]) begin
      check("req_ready_timeout", 32'(req_ready_v[sel]), 32'd1);
      return;
    end
    push_line(a);
    req_valid_v[sel] = 1'b1;
    req_addr_v[sel]  = a;
    req_abort_v[sel] = abort_at_acc;
    @(negedge clk);
    req_valid_v[sel] = 1'b0;
    req_abort_v[sel] = 1'b0;
    req_addr_v[sel]  = $urandom;
    n = 1;
    while (!rsp_valid_v[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_beat_latency", 32'(n), 32'(exp_lat));
    if (!rsp_valid_v[sel]) begin
      exp_q.delete();
      return;
    end
    beats = 0;
    vcyc = 0;
    stalled = 0;
    while (rsp_valid_v[sel] && vcyc < 200) begin
      vcyc++;
      force_stall[sel] = (stall_len > 0) && (beats == stall_at - 1) && (stalled < stall_len);
      if (force_stall[sel]) stalled++;
      if (ld_first && vcyc == 1) begin
        ld_we   = 1'b1;
        ld_addr = a + 32'd1;
        ld_data = 32'hDEAD_BEEF;
        ref_mem[8'(a + 32'd1)] = 32'hDEAD_BEEF;
      end else begin
        ld_we = 1'b0;
      end
      hs = rsp_valid_v[sel] && !force_stall[sel] && (!rnd_mode || rnd_bit[sel]);
      if (hs) beats++;
      if (hs && rst_after > 0 && beats == rst_after) begin
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid_v[sel]), 32'd0);
        check("rst_rsp_data", rsp_data_v[sel], 32'd0);
        check("rst_rsp_idx", 32'(rsp_idx_v[sel]), 32'd0);
        check("rst_busy", 32'(busy_v[sel]), 32'd0);
        check("rst_req_ready", 32'(req_ready_v[sel]), 32'd1);
        exp_q.delete();
        @(negedge clk);
        force_stall[sel] = 1'b0;
        ld_we = 1'b0;
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    ld_we = 1'b0;
    force_stall[sel] = 1'b0;
    check("beats_delivered", 32'(beats), 32'(W));
    if (chk_timing) check("burst_cycles", 32'(vcyc), 32'(W + stall_len));
    check("req_ready_after_line", 32'(req_ready_v[sel]), 32'd1);
    check("busy_after_line", 32'(busy_v[sel]), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // request without expected beats, aborted during WAIT cycle abort_cyc
  task automatic run_abort(input int sel, input logic [31:0] a, input int abort_cyc);
    req_valid_v[sel] = 1'b1;
    req_addr_v[sel]  = a;
    @(negedge clk);
    req_valid_v[sel] = 1'b0;
    for (int c = 1; c < abort_cyc; c++) begin
      check("wait_busy", 32'(busy_v[sel]), 32'd1);
      @(negedge clk);
    end
    req_abort_v[sel] = 1'b1;
    @(negedge clk);
    req_abort_v[sel] = 1'b0;
    check("abort_busy", 32'(busy_v[sel]), 32'd0);
    check("abort_req_ready", 32'(req_ready_v[sel]), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid_v[sel]), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int w;
    logic [31:0] ra;
    rst_n = 1'b0;
    req_valid_v = '0;
    req_abort_v = '0;
    req_addr_v = '0;
    force_stall = '0;
    rnd_bit = '0;
    rnd_mode = 1'b0;
    ld_we = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset_req_ready", 32'(req_ready_v[g]), 32'd1);
      check("reset_busy", 32'(busy_v[g]), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid_v[g]), 32'd0);
      check("reset_rsp_data", rsp_data_v[g], 32'd0);
      check("reset_rsp_idx", 32'(rsp_idx_v[g]), 32'd0);
      check("reset_rsp_last", 32'(rsp_last_v[g]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < DEPTH; k++) begin
      ld_we = 1'b1;
      ld_addr = 32'(k);
      ld_data = 32'h1000 + 32'(k);
      ref_mem[k] = 32'h1000 + 32'(k);
      @(negedge clk);
    end
    ld_we = 1'b0;
    @(negedge clk);

    // plain line, then the same line with a two-cycle stall on beat 2
    run_line(0, 32'h12, 3, 0, 0, 0, 0, 1, 0, w);
    run_line(0, 32'h12, 3, 2, 2, 0, 0, 1, 0, w);
    // abort in the second WAIT cycle, then a fresh line
    run_abort(0, 32'h20, 2);
    run_line(0, 32'h24, 3, 0, 0, 0, 0, 1, 0, w);
    // reset after two beats, then the same line again
    run_line(0, 32'h30, 3, 0, 0, 0, 2, 1, 0, w);
    repeat (2) @(negedge clk);
    run_line(0, 32'h30, 3, 0, 0, 0, 0, 1, 0, w);
    // LATENCY=1 back-to-back: the second accept happens in the single idle cycle
    run_line(1, 32'h00, 1, 0, 0, 0, 0, 1, 0, w);
    run_line(1, 32'h07, 1, 0, 0, 0, 0, 1, 0, w);
    check("b2b_ready_wait", 32'(w), 32'd0);
    // preload coinciding with the beat load, then read back the new word first
    run_line(0, 32'h40, 3, 0, 0, 1, 0, 1, 0, w);
    run_line(0, 32'h41, 3, 0, 0, 0, 0, 1, 0, w);
    // abort alongside the accept in IDLE is ignored
    run_line(0, 32'h55, 3, 0, 0, 0, 0, 1, 1, w);

    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        ra = $urandom;
        ld_we = 1'b1;
        ld_addr = ra;
        ld_data = $urandom;
        ref_mem[ra[7:0]] = ld_data;
        @(negedge clk);
        ld_we = 1'b0;
      end
      ra = $urandom;
      run_line(sel, ra, (sel == 0) ? 3 : 1, 0, 0, 0, 0, 0, ($urandom_range(0, 3) == 0), w);
    end
    rnd_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_refill_responder.md
Name: imem_refill_responder

Overview:
- Backing-store responder for the instruction cache's line-refill interface: the memory side that answers the Icache's miss requests.
- Accepts one line-refill request at a time and waits a programmable access latency.
- Returns WORDS_PER_LINE 32-bit instruction words, critical-word-first with wrap inside the line, over a valid/ready burst.
- Supports abort on branch redirect, plus a side write port for program preload.
- Addresses are word addresses, consistent with the datapath's PC+1 stepping.

Parameters:
ADDR_W, 32, request/preload address width (word address)
WORDS_PER_LINE, 4, words per cache line; power of two, >=2
LATENCY, 3, cycles from request accept to first rsp_valid; >=1
MEM_DEPTH, 256, storage depth in words; power of two

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  refill request present
req_ready  output  1  responder can accept a request (high only in IDLE)
req_addr  input  ADDR_W  word address of the missing (critical) word
req_abort  input  1  cancel the outstanding refill (branch redirect)
rsp_valid  output  1  rsp_data holds a valid beat
rsp_ready  input  1  cache accepts the current beat
rsp_data  output  32  instruction word
rsp_idx  output  log2(WORDS_PER_LINE)  word offset within the line of the current beat
rsp_last  output  1  current beat is the final beat of the line
busy  output  1  state != IDLE
ld_we  input  1  preload write enable
ld_addr  input  ADDR_W  preload word address
ld_data  input  32  preload data

Behaviour:
- **Reset (rst=0, async):**
  - state=IDLE, so req_ready=1 and busy=0.
  - rsp_valid=0, rsp_data=0, rsp_idx=0, rsp_last=0.
  - Beat and latency counters are cleared. Memory contents are not reset.
- **Storage index:** addr mod MEM_DEPTH (low bits only); out-of-range addresses alias, with no error.
- **Preload:** ld_we writes mem[ld_addr] at the clk edge in any state.
  - A beat loaded on the same edge gets the pre-write value.
- **FSM states:**
  - IDLE: req_ready=1. On req_valid, latch base = req_addr with the low log2(WORDS) bits cleared, and start offset = req_addr low bits.
    - If LATENCY=1, go to BURST (rsp_data loads mem[req_addr]).
    - Otherwise go to WAIT with latency count LATENCY-1.
    - req_abort is ignored in IDLE; a request in that cycle is still accepted.
  - WAIT: decrement the count each cycle. When it reaches 1, load rsp_data/rsp_idx for the start offset and go to BURST.
    - Net result: the first rsp_valid is exactly LATENCY cycles after the accept edge.
  - BURST: rsp_valid=1.
    - rsp_data, rsp_idx and rsp_last are registered and stable while rsp_ready=0.
    - On rsp_valid&&rsp_ready: idx = (idx+1) mod WORDS, rsp_data = mem[base|idx_next], beat count increments.
    - rsp_last=1 on beat number WORDS (the beat whose idx = start-1 mod WORDS).
    - Handshake on the last beat: go to IDLE. rsp_valid=0 and req_ready=1 on the next cycle; a new request can then be accepted that cycle.
- **Abort:** req_abort in WAIT or BURST returns to IDLE at the next edge. rsp_valid drops to 0 and no further beats are issued.
  - Abort coincident with the last-beat handshake: the beat counts as delivered; result is IDLE either way.
- **Outputs:** no beat is issued twice and no beat is skipped; exactly WORDS handshakes per non-aborted request.
- **Reset mid-burst:** immediate return to the reset values; the request is lost and not replayed.
- **Timing:** no combinational path from rsp_ready or req_valid to any output except through the state registers; req_ready is decoded from state only.

Test Plan:
1. Preload mem[k]=0x1000+k for k=0..255. With WORDS=4, LATENCY=3, rsp_ready=1, request 0x12.
   - Required: first rsp_valid 3 cycles after accept.
   - Beats 0x1012, 0x1013, 0x1010, 0x1011 with rsp_idx 2, 3, 0, 1.
   - rsp_last only on 0x1011; req_ready=1 the cycle after.
2. Same request with rsp_ready=0 for 2 cycles at beat 2.
   - Required: rsp_data holds 0x1013 and rsp_idx 3 while stalled.
   - Burst completes in 4+2 cycles, with no duplicate or missing beat.
3. Request 0x20, then req_abort in the second WAIT cycle.
   - Required: rsp_valid never asserts, busy=0 and req_ready=1 the next cycle.
   - A new request 0x24 returns 0x1024..0x1027.
4. Drop rst to 0 asynchronously mid-burst (after 2 beats of request 0x30).
   - Required: rsp_valid=0, rsp_data=0, busy=0 immediately.
   - After release, request 0x30 delivers all 4 beats from 0x1030.
5. Run with LATENCY=1 and back-to-back requests 0x00 and 0x07.
   - Required: first beat 1 cycle after each accept.
   - Second line beats are 0x1007, 0x1004, 0x1005, 0x1006.
   - Requests are separated by exactly one IDLE cycle.
6. Assert ld_we to ld_addr=0x41 (data 0xDEADBEEF) on the same edge that loads beat 0x41 of request 0x40.
   - Required: the beat returns 0x1041.
   - A subsequent request 0x41 returns 0xDEADBEEF first.
